// File: rtl/reg_file_pkg.sv
// Shared constants, types and state encoding for the reg_file_wb register file.
// Optional feature macro: REG_FILE_WB_ZERO_REG_EN (register 0 hardwired to zero).
package reg_file_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREGS  = 1 << ADDR_W;

  // Behavioural timing of the original model: reads settle 2 time units after
  // an input change, register/buffer updates land 1 time unit after posedge.
  // The RTL is zero-delay; these name the sampling points a bench should use.
  localparam int unsigned READ_DELAY  = 2;
  localparam int unsigned WRITE_DELAY = 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } wb_state_e;

  // True when a write to this address must be discarded (hardwired zero reg).
  function automatic logic zero_blocked(input addr_t addr);
`ifdef REG_FILE_WB_ZERO_REG_EN
    return (addr == '0);
`else
    return 1'b0;
`endif
  endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Bus bundle between the pipeline (master) and the reg_file_wb register file (slave).
// Optional feature macro: REG_FILE_WB_ZERO_REG_EN (no effect on the interface).
interface reg_file_wb_if;
  import reg_file_pkg::*;

  data_t in;
  addr_t inaddress;
  logic  write;
  logic  busywait;
  addr_t out1address;
  addr_t out2address;
  data_t out1;
  data_t out2;
  logic  pending;

  modport master (
    output in, inaddress, write, busywait, out1address, out2address,
    input  out1, out2, pending
  );

  modport slave (
    input  in, inaddress, write, busywait, out1address, out2address,
    output out1, out2, pending
  );

endinterface

// File: rtl/reg_file_wbuf.sv
// One-entry write-back buffer: holds an ALU result while memory stalls and
// produces a single commit (enable, address, data) for the register array.
// Optional feature macro: REG_FILE_WB_ZERO_REG_EN (writes to register 0 never
// commit and are never captured).
module reg_file_wbuf
  import reg_file_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  write,
  input  logic  busywait,
  input  addr_t wr_addr,
  input  data_t wr_data,
  output logic  commit_en,
  output addr_t commit_addr,
  output data_t commit_data,
  output logic  pending,
  output addr_t pend_addr,
  output data_t pend_data
);

  wb_state_e state_q;
  logic      pending_q;
  addr_t     pend_addr_q;
  data_t     pend_data_q;

  logic accept;
  logic same_pair;
  logic new_req;

  // Classify the incoming request against the buffered entry.
  always_comb begin
    accept    = write && !zero_blocked(wr_addr);
    same_pair = (wr_addr == pend_addr_q) && (wr_data == pend_data_q);
    // A stalled retry re-presents the buffered pair; only a different pair is new.
    new_req   = accept && !same_pair;
  end

  // Commit select: the buffer has priority; otherwise an unstalled write goes straight in.
  always_comb begin
    commit_en   = 1'b0;
    commit_addr = wr_addr;
    commit_data = wr_data;
    if (state_q == StHold) begin
      commit_en   = !busywait;
      commit_addr = pend_addr_q;
      commit_data = pend_data_q;
    end else begin
      commit_en   = accept && !busywait;
    end
  end

  // Buffer FSM with registered PENDING/PEND_ADDR/PEND_DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && busywait) begin
            pend_addr_q <= wr_addr;
            pend_data_q <= wr_data;
            pending_q   <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (new_req) begin
            // Last request wins while stalled; after a commit edge it becomes
            // the next entry and waits for the following unstalled edge.
            pend_addr_q <= wr_addr;
            pend_data_q <= wr_data;
            pending_q   <= 1'b1;
          end else if (!busywait) begin
            pending_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign pending   = pending_q;
  assign pend_addr = pend_addr_q;
  assign pend_data = pend_data_q;

endmodule

// File: rtl/reg_file_wb.sv
// 8 x 8-bit register file with a one-entry write-back buffer and read forwarding.
// Read ports feed the ADD unit DATA1/DATA2; the write port takes the ALU result.
// Optional feature macro: REG_FILE_WB_ZERO_REG_EN (register 0 reads as zero,
// writes to it are dropped).
module reg_file_wb
  import reg_file_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  reg_file_wb_if.slave  bus
);

  data_t regs_q [NREGS];

  logic  commit_en;
  addr_t commit_addr;
  data_t commit_data;
  logic  pending;
  addr_t pend_addr;
  data_t pend_data;

  reg_file_wbuf u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .write       (bus.write),
    .busywait    (bus.busywait),
    .wr_addr     (bus.inaddress),
    .wr_data     (bus.in),
    .commit_en   (commit_en),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .pending     (pending),
    .pend_addr   (pend_addr),
    .pend_data   (pend_data)
  );

  // Register array: at most one write per edge, sourced by the buffer's commit port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_en) begin
      regs_q[commit_addr] <= commit_data;
    end
  end

  // Read port 1: forward the uncommitted buffer entry over the array contents.
  always_comb begin
    bus.out1 = regs_q[bus.out1address];
    if (pending && (bus.out1address == pend_addr)) begin
      bus.out1 = pend_data;
    end
`ifdef REG_FILE_WB_ZERO_REG_EN
    if (bus.out1address == '0) begin
      bus.out1 = '0;
    end
`endif
  end

  // Read port 2: same forwarding rule as port 1.
  always_comb begin
    bus.out2 = regs_q[bus.out2address];
    if (pending && (bus.out2address == pend_addr)) begin
      bus.out2 = pend_data;
    end
`ifdef REG_FILE_WB_ZERO_REG_EN
    if (bus.out2address == '0) begin
      bus.out2 = '0;
    end
`endif
  end

  assign bus.pending = pending;

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 8 x 8-bit register file for the simple processor.
- Directly upstream of the ADD unit: the two read ports drive DATA1/DATA2.
- Its write port takes the ALU/ADD RESULT back.
- Adds a one-entry write-back buffer so an ALU result produced while the pipeline stalls on memory BUSYWAIT is held, forwarded to readers, and committed when the stall clears.

Parameters:
- DATA_W, 8, register and data width.
- ADDR_W, 3, register address width.
- NREGS, 8, number of registers (2**ADDR_W).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- IN  input  DATA_W  write data (ALU RESULT).
- INADDRESS  input  ADDR_W  write register index.
- WRITE  input  1  write request.
- BUSYWAIT  input  1  memory stall; writes may not commit while high.
- OUT1ADDRESS  input  ADDR_W  read port 1 index.
- OUT2ADDRESS  input  ADDR_W  read port 2 index.
- OUT1  output  DATA_W  read data 1 (to ADD DATA1).
- OUT2  output  DATA_W  read data 2 (to ADD DATA2).
- PENDING  output  1  write buffer holds an uncommitted write.

Behaviour:
- Reads are combinational, #2 delay.
- OUTn = PEND_DATA if PENDING and OUTnADDRESS == PEND_ADDR; otherwise regs[OUTnADDRESS] (forwarding).
- Register and buffer updates occur at posedge CLK with #1 delay.
- RESET (sampled at posedge, highest priority, including mid-HOLD):
  - all regs = 0, PENDING = 0, PEND_ADDR = 0, PEND_DATA = 0, state = IDLE.
  - Any buffered write is discarded.
  - After reset, OUT1 = OUT2 = 0.
- State IDLE:
  - WRITE & !BUSYWAIT: regs[INADDRESS] <= IN; stay IDLE. Write latency 1 edge; visible on OUTn #2 after the register update.
  - WRITE & BUSYWAIT: PEND_ADDR/PEND_DATA <= INADDRESS/IN, PENDING <= 1, go HOLD. Register array unchanged.
  - !WRITE: no change.
- State HOLD:
  - BUSYWAIT high: buffer frozen.
  - WRITE re-presenting the same (INADDRESS, IN) as the buffer is the stalled retry and is ignored.
  - WRITE with a different address or data while BUSYWAIT is high overwrites the buffer (last request wins).
  - BUSYWAIT low: regs[PEND_ADDR] <= PEND_DATA.
    - If WRITE is asserted with a pair equal to the buffer: PENDING <= 0, go IDLE (no double write).
    - If WRITE is asserted with a different pair: capture it as the new buffer entry, PENDING stays 1, remain HOLD. It commits on the next edge with BUSYWAIT low.
    - If WRITE is low: PENDING <= 0, go IDLE.
- Only one register write occurs per edge. The buffer is never lost except by RESET.
- No arithmetic; widths are exact. Address wrap is not possible (index range = NREGS).

Optional Feature:
- Macro: REG_FILE_WB_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to 0; reads of address 0 return 0, including when forwarding.
  - A write to address 0 is dropped in IDLE.
  - In HOLD, a write to address 0 is not captured and PENDING is not set.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package/header reg_file_pkg:
  - DATA_W, ADDR_W, NREGS constants.
  - State encoding IDLE = 1'b0, HOLD = 1'b1.
  - Read delay 2 and write delay 1 as named constants.
- One natural sub-module: reg_file_wbuf.
  - Contains the write-buffer FSM, PEND_ADDR/PEND_DATA/PENDING and the commit-select logic.
  - Outputs a single commit enable, address and data to the array in reg_file_wb.
- The array and read/forward muxes stay in the top.

Test Plan:
- RESET after arbitrary writes -> every address reads 0 on both ports, PENDING = 0.
- IDLE, WRITE=1, INADDRESS=3, IN=8'h2A, BUSYWAIT=0 -> after edge OUT1ADDRESS=3 gives 8'h2A; OUT2ADDRESS=4 still 0.
- BUSYWAIT=1, WRITE 5/8'h11 held for 4 cycles -> PENDING=1, OUT1(5)=8'h11 via forwarding, regs[5] unchanged. BUSYWAIT drops -> one commit, PENDING=0, regs[5]=8'h11.
- HOLD with pending 5/8'h11; at the BUSYWAIT-falling edge WRITE 6/8'h22 -> regs[5]=8'h11, PENDING stays 1 with 6/8'h22. Next edge -> regs[6]=8'h22, IDLE.
- HOLD with pending 2/8'hFF, RESET asserted -> regs[2]=0, PENDING=0, IDLE; subsequent BUSYWAIT low commits nothing.
- With REG_FILE_WB_ZERO_REG_EN: WRITE 0/8'h55 in IDLE and under BUSYWAIT -> OUT1(0)=0, PENDING stays 0. Without the macro -> OUT1(0)=8'h55.
